// File: rtl/led_pwm_pkg.sv
// Shared types and defaults for the LED PWM driver.
// Optional build macro: LED_PWM_PHASE_STAGGER_EN (per-channel phase offset, see top).
package led_pwm_pkg;

   localparam int unsigned PWM_WIDTH_DEF      = 8;
   localparam int unsigned PRESCALE_WIDTH_DEF = 16;

   typedef logic [PWM_WIDTH_DEF-1:0]      pwm_duty_t;
   typedef logic [PRESCALE_WIDTH_DEF-1:0] prescale_t;

   // Reset/default brightness: full on.
   localparam pwm_duty_t PWM_DUTY_FULL = '1;

endpackage

// File: rtl/led_pwm_prescaler.sv
// Prescaler for the LED PWM driver: pulses tick once every prescale+1 enabled cycles.
// The prescale input is sampled only on reload, so a change takes effect at the next tick.
module led_pwm_prescaler
   import led_pwm_pkg::*;
#(
   parameter int unsigned PRESCALE_WIDTH = PRESCALE_WIDTH_DEF
) (
   input  logic                      clk,
   input  logic                      async_rst_n,
   input  logic                      clk_en,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   output logic                      tick
);

   logic [PRESCALE_WIDTH-1:0] pre_cnt_q;

   assign tick = clk_en && (pre_cnt_q == '0);

   always_ff @(posedge clk or negedge async_rst_n) begin
      if (!async_rst_n) begin
         pre_cnt_q <= '0;
      end else if (clk_en) begin
         if (pre_cnt_q == '0) begin
            pre_cnt_q <= prescale;
         end else begin
            pre_cnt_q <= pre_cnt_q - PRESCALE_WIDTH'(1);
         end
      end
   end

endmodule

// File: rtl/led_pwm_driver_generic.sv
// LED bank driver with per-channel enable and double-buffered PWM brightness.
// Define LED_PWM_PHASE_STAGGER_EN to offset each channel's PWM phase by i*2**PWM_WIDTH/CHANNELS.
module led_pwm_driver_generic
   import led_pwm_pkg::*;
#(
   parameter int unsigned CHANNELS       = 8,
   parameter int unsigned PWM_WIDTH      = PWM_WIDTH_DEF,
   parameter int unsigned PRESCALE_WIDTH = PRESCALE_WIDTH_DEF,
   localparam int unsigned SEL_WIDTH     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                      clk,
   input  logic                      async_rst_n,
   input  logic                      clk_en,
   input  logic [CHANNELS-1:0]       data_in,
   input  logic                      update_leds,
   input  logic [PWM_WIDTH-1:0]      brightness,
   input  logic [SEL_WIDTH-1:0]      brightness_sel,
   input  logic                      update_brightness,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   output logic [CHANNELS-1:0]       leds_out
);

   localparam logic [PWM_WIDTH-1:0] DUTY_FULL = {PWM_WIDTH{PWM_DUTY_FULL[0]}};
`ifdef LED_PWM_PHASE_STAGGER_EN
   localparam int unsigned PHASE_STEP = (2 ** PWM_WIDTH) / CHANNELS;
`endif

   logic                 tick;
   logic                 boundary;
   logic [CHANNELS-1:0]  enable_q;
   logic [PWM_WIDTH-1:0] pwm_cnt_q;
   logic [PWM_WIDTH-1:0] pending_q    [CHANNELS];
   logic [PWM_WIDTH-1:0] active_q     [CHANNELS];
   logic [PWM_WIDTH-1:0] pending_next [CHANNELS];
   logic [PWM_WIDTH-1:0] phase        [CHANNELS];
   logic [CHANNELS-1:0]  lit;

   led_pwm_prescaler #(
      .PRESCALE_WIDTH (PRESCALE_WIDTH)
   ) u_prescaler (
      .clk         (clk),
      .async_rst_n (async_rst_n),
      .clk_en      (clk_en),
      .prescale    (prescale),
      .tick        (tick)
   );

   assign boundary = tick && (pwm_cnt_q == DUTY_FULL);

   // Out-of-range selects match no channel and are dropped.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         pending_next[i] = pending_q[i];
         if (update_brightness && (brightness_sel == SEL_WIDTH'(i))) begin
            pending_next[i] = brightness;
         end
      end
   end

   always_comb begin
      lit = '0;
      for (int i = 0; i < CHANNELS; i++) begin
`ifdef LED_PWM_PHASE_STAGGER_EN
         phase[i] = pwm_cnt_q + PWM_WIDTH'(unsigned'(i) * PHASE_STEP);
`else
         phase[i] = pwm_cnt_q;
`endif
         lit[i] = enable_q[i] && ((active_q[i] == DUTY_FULL) || (phase[i] < active_q[i]));
      end
   end

   always_ff @(posedge clk or negedge async_rst_n) begin
      if (!async_rst_n) begin
         enable_q  <= '0;
         pwm_cnt_q <= '0;
         leds_out  <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            pending_q[i] <= DUTY_FULL;
            active_q[i]  <= DUTY_FULL;
         end
      end else if (clk_en) begin
         if (update_leds) begin
            enable_q <= data_in;
         end
         if (tick) begin
            pwm_cnt_q <= pwm_cnt_q + PWM_WIDTH'(1);
         end
         // pending_next bypasses a same-cycle write straight into active at the boundary.
         for (int i = 0; i < CHANNELS; i++) begin
            pending_q[i] <= pending_next[i];
            if (boundary) begin
               active_q[i] <= pending_next[i];
            end
         end
         leds_out <= lit;
      end
   end

endmodule

// File: tb/tb_led_pwm_driver_generic.sv
// Self-checking bench for led_pwm_driver_generic (8 channels, 8-bit PWM).
module tb_led_pwm_driver_generic;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        clk_en = 1'b1;
   logic [7:0]  data_in = '0;
   logic        update_leds = 1'b0;
   logic [7:0]  brightness = '0;
   logic [2:0]  brightness_sel = '0;
   logic        update_brightness = 1'b0;
   logic [15:0] prescale = '0;
   logic [7:0]  leds_out;

   int n_cmp = 0;
   int n_fail = 0;

   led_pwm_driver_generic #(
      .CHANNELS       (8),
      .PWM_WIDTH      (8),
      .PRESCALE_WIDTH (16)
   ) dut (
      .clk               (clk),
      .async_rst_n       (rst_n),
      .clk_en            (clk_en),
      .data_in           (data_in),
      .update_leds       (update_leds),
      .brightness        (brightness),
      .brightness_sel    (brightness_sel),
      .update_brightness (update_brightness),
      .prescale          (prescale),
      .leds_out          (leds_out)
   );

   always #5 clk = ~clk;

   // Reference model: integer counters, duty rule applied directly per channel.
   logic [7:0] m_en;
   int         m_pend [8];
   int         m_act  [8];
   int         m_pwm;
   int         m_pre;
   logic [7:0] m_leds;
   bit         m_tick;
   int         m_ph;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_en = '0;
         m_pwm = 0;
         m_pre = 0;
         m_leds = '0;
         for (int i = 0; i < 8; i++) begin
            m_pend[i] = 255;
            m_act[i] = 255;
         end
      end else if (clk_en) begin
         m_tick = (m_pre == 0);
         for (int i = 0; i < 8; i++) begin
`ifdef LED_PWM_PHASE_STAGGER_EN
            m_ph = (m_pwm + i * 32) % 256;
`else
            m_ph = m_pwm;
`endif
            m_leds[i] = m_en[i] && (m_act[i] == 255 || m_ph < m_act[i]);
         end
         if (update_brightness && int'(brightness_sel) < 8) m_pend[brightness_sel] = brightness;
         if (m_tick && m_pwm == 255) begin
            for (int i = 0; i < 8; i++) m_act[i] = m_pend[i];
         end
         if (m_tick) m_pwm = (m_pwm + 1) % 256;
         m_pre = m_tick ? int'(prescale) : m_pre - 1;
         if (update_leds) m_en = data_in;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One clock; outputs sampled on the falling edge and compared with the model.
   task automatic cyc();
      @(negedge clk);
      n_cmp++;
      if (leds_out !== m_leds) begin
         n_fail++;
         $display("FAIL model_track t=%0t: leds_out=%h expected %h", $time, leds_out, m_leds);
      end
   endtask

   task automatic count_lit(input int ch, input int n, output int c);
      c = 0;
      repeat (n) begin
         cyc();
         c += int'(leds_out[ch]);
      end
   endtask

   task automatic wait_pwm(input int v, input string name);
      bit found = 1'b0;
      for (int k = 0; k < 4000; k++) begin
         cyc();
         if (m_pwm == v) begin
            found = 1'b1;
            break;
         end
      end
      check({name, "_timeout"}, int'(found), 1);
   endtask

   task automatic write_b(input int ch, input int val);
      brightness_sel = 3'(ch);
      brightness = 8'(val);
      update_brightness = 1'b1;
      cyc();
      update_brightness = 1'b0;
   endtask

   typedef struct {
      logic [7:0] bright;
      logic [2:0] sel;
      logic [7:0] en;
      int         exp_cnt;
   } vec_t;

   vec_t vecs [6];

   initial begin
      int c;
      vecs[0] = '{8'd64,  3'd0, 8'h01, 64};
      vecs[1] = '{8'd0,   3'd0, 8'h01, 0};
      vecs[2] = '{8'hFF,  3'd0, 8'h01, 256};
      vecs[3] = '{8'd128, 3'd3, 8'h08, 128};
      vecs[4] = '{8'd1,   3'd5, 8'h20, 1};
      vecs[5] = '{8'd200, 3'd7, 8'h80, 200};

      #1 rst_n = 1'b0;
      #12 rst_n = 1'b1;
      cyc();
      check("reset_leds", int'(leds_out), 0);

      // Enable-only behaviour at full brightness.
      data_in = 8'hA5;
      update_leds = 1'b1;
      cyc();
      update_leds = 1'b0;
      check("enable_latency_not_yet", int'(leds_out), 0);
      cyc();
      check("enable_visible", int'(leds_out), 8'hA5);
      c = 0;
      repeat (300) begin
         cyc();
         if (leds_out == 8'hA5) c++;
      end
      check("enable_constant", c, 300);

      // Duty table; enable and brightness written in the same cycle.
      for (int v = 0; v < 6; v++) begin
         data_in = vecs[v].en;
         update_leds = 1'b1;
         brightness_sel = vecs[v].sel;
         brightness = vecs[v].bright;
         update_brightness = 1'b1;
         cyc();
         update_leds = 1'b0;
         update_brightness = 1'b0;
         repeat (300) cyc();
         count_lit(int'(vecs[v].sel), 256, c);
         check($sformatf("duty_vec%0d", v), c, vecs[v].exp_cnt);
      end

      // Mid-period write holds until the wrap; boundary-cycle write applies immediately.
      data_in = 8'h08;
      update_leds = 1'b1;
      cyc();
      update_leds = 1'b0;
      write_b(3, 255);
      repeat (300) cyc();
      wait_pwm(100, "wait100");
      write_b(3, 128);
      count_lit(3, 150, c);
      check("midperiod_hold", c, 150);
      wait_pwm(255, "wait255a");
      repeat (2) cyc();
      count_lit(3, 256, c);
      check("midperiod_applied", c, 128);
      wait_pwm(255, "wait255b");
      write_b(3, 0);
      count_lit(3, 256, c);
      check("boundary_bypass", c, 0);

      // Prescale 3: period is 1024 cycles.
      prescale = 16'd3;
      data_in = 8'h01;
      update_leds = 1'b1;
      cyc();
      update_leds = 1'b0;
      write_b(0, 64);
      repeat (1100) cyc();
      count_lit(0, 1024, c);
      check("prescale3_duty", c, 256);

      // clk_en low freezes everything.
      wait_pwm(30, "wait30");
      begin
         logic [7:0] held;
         held = m_leds;
         clk_en = 1'b0;
         data_in = 8'h00;
         update_leds = 1'b1;
         c = 0;
         repeat (10) begin
            cyc();
            if (leds_out == held) c++;
         end
         check("freeze_hold", c, 10);
         check("freeze_lit_value", int'(held[0]), 1);
         update_leds = 1'b0;
         clk_en = 1'b1;
      end
      count_lit(0, 1024, c);
      check("after_freeze_duty", c, 256);

      // Async reset mid-period.
      prescale = 16'd0;
      data_in = 8'hFF;
      update_leds = 1'b1;
      cyc();
      update_leds = 1'b0;
      wait_pwm(40, "wait40");
      check("pre_reset_lit", int'(leds_out[0]), 1);
      #2 rst_n = 1'b0;
      #1 check("async_reset_immediate", int'(leds_out), 0);
      cyc();
      rst_n = 1'b1;
      data_in = 8'hFF;
      update_leds = 1'b1;
      cyc();
      update_leds = 1'b0;
      c = 0;
      repeat (300) begin
         cyc();
         if (leds_out == 8'hFF) c++;
      end
      check("post_reset_full", c, 300);

      // Randomised traffic against the model.
      for (int k = 0; k < 3000; k++) begin
         clk_en = ($urandom_range(0, 9) < 8);
         update_leds = ($urandom_range(0, 9) == 0);
         data_in = 8'($urandom);
         update_brightness = ($urandom_range(0, 4) == 0);
         brightness_sel = 3'($urandom);
         case ($urandom_range(0, 3))
            0: brightness = 8'h00;
            1: brightness = 8'hFF;
            default: brightness = 8'($urandom);
         endcase
         if ($urandom_range(0, 49) == 0) prescale = 16'($urandom_range(0, 3));
         cyc();
      end
      clk_en = 1'b1;
      update_leds = 1'b0;
      update_brightness = 1'b0;
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
